// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction RAM; captures the debug word stream, then serves core fetches.
module imem_loader #(
  parameter int DEPTH = 1024,
  parameter int ADDR_W = 10,
  parameter logic [31:0] NOP = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              debug_sig,
  input  logic [31:0]       debug_addr,
  input  logic [31:0]       debug_instr,
  input  logic              debug_start,
  input  logic              fetch_en,
  input  logic [31:0]       fetch_pc,
  output logic [31:0]       fetch_instr,
  output logic              fetch_valid,
  output logic              core_en,
  output logic [ADDR_W:0]   load_count,
  output logic              load_err
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W:0] load_count_q, load_count_d;
  logic load_err_q, load_err_d, fv_q, fv_d, ok_q, ok_d;
  logic in_range, loading, accept, fetch;
  logic [31:0] ram_q;
  logic [31:0] mem [DEPTH];
  always_comb begin
    in_range = debug_addr[31:ADDR_W] == '0;
    loading = state_q != RUN && debug_sig;
    accept = loading && in_range;
    fetch = fetch_en && state_q == RUN;
    state_d = (state_q == RUN || debug_start) ? RUN : debug_sig ? LOAD : state_q;
    load_count_d = (accept && load_count_q != (ADDR_W+1)'(DEPTH)) ? load_count_q + 1'b1 : load_count_q;
    load_err_d = load_err_q | (loading && !in_range);
    fv_d = fetch;
    ok_d = fetch && fetch_pc[1:0] == 2'b00 && fetch_pc[31:ADDR_W+2] == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      load_count_q <= '0;
      load_err_q <= 1'b0;
      fv_q <= 1'b0;
      ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      load_count_q <= load_count_d;
      load_err_q <= load_err_d;
      fv_q <= fv_d;
      ok_q <= ok_d;
    end
  end
  // RAM kept reset-free so it maps onto block RAM; invalid fetches are masked after the read register
  always_ff @(posedge clk) begin
    if (accept) mem[debug_addr[ADDR_W-1:0]] <= debug_instr;
    if (fetch) ram_q <= mem[fetch_pc[ADDR_W+1:2]];
  end
  assign core_en = state_q == RUN;
  assign fetch_valid = fv_q;
  assign fetch_instr = ok_q ? ram_q : NOP;
  assign load_count = load_count_q;
  assign load_err = load_err_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed stimulus with a fetch scoreboard checked by an independent monitor.
module tb_imem_loader;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk = 0, rst = 0, debug_sig = 0, debug_start = 0, fetch_en = 0;
  logic [31:0] debug_addr = 0, debug_instr = 0, fetch_pc = 0;
  logic [31:0] fetch_instr;
  logic fetch_valid, core_en, load_err;
  logic [10:0] load_count;
  logic [31:0] exp_q[$];
  int checks = 0, errors = 0;

  imem_loader dut (
    .clk(clk), .rst(rst), .debug_sig(debug_sig), .debug_addr(debug_addr),
    .debug_instr(debug_instr), .debug_start(debug_start), .fetch_en(fetch_en),
    .fetch_pc(fetch_pc), .fetch_instr(fetch_instr), .fetch_valid(fetch_valid),
    .core_en(core_en), .load_count(load_count), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    debug_sig = 1; debug_addr = a; debug_instr = d;
    tick();
    debug_sig = 0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] exp);
    fetch_en = 1; fetch_pc = pc;
    exp_q.push_back(exp);
    tick();
    fetch_en = 0;
  endtask

  always @(negedge clk) begin
    if (fetch_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_fetch: got %h with no fetch outstanding", fetch_instr);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (fetch_instr !== e) begin
          errors++;
          $display("FAIL fetch_word: got %h expected %h", fetch_instr, e);
        end
      end
    end else if (fetch_instr !== NOP) begin
      errors++;
      $display("FAIL idle_instr: got %h expected %h", fetch_instr, NOP);
    end
  end

  initial begin
    rst = 1; tick(); tick(); rst = 0;
    check("rst_core_en", 32'(core_en), 0);
    check("rst_fetch_valid", 32'(fetch_valid), 0);
    check("rst_fetch_instr", fetch_instr, NOP);
    check("rst_load_count", 32'(load_count), 0);
    check("rst_load_err", 32'(load_err), 0);

    load(0, 32'h002081B3);
    load(1, 32'h0040006F);
    load(2, 32'h00A58633);
    check("load_count_3", 32'(load_count), 3);
    fetch_en = 1; fetch_pc = 0; tick(); fetch_en = 0;
    check("no_run_core_en", 32'(core_en), 0);

    load(1024, 32'h11111111);
    check("oor_err", 32'(load_err), 1);
    load(32'hFFFFFFFF, 32'h22222222);
    check("oor_count", 32'(load_count), 3);

    debug_sig = 1; debug_addr = 5; debug_instr = 32'h00500093; debug_start = 1;
    tick();
    debug_sig = 0;
    check("start_count", 32'(load_count), 4);
    check("start_core_en", 32'(core_en), 1);
    check("start_err_sticky", 32'(load_err), 1);

    fetch(32'h4, 32'h0040006F);
    tick();
    fetch(32'h0, 32'h002081B3);
    fetch(32'h8, 32'h00A58633);
    fetch(32'h14, 32'h00500093);

    load(0, 32'hDEADBEEF);
    check("run_count", 32'(load_count), 4);
    fetch(32'h0, 32'h002081B3);
    fetch(32'h6, NOP);
    fetch(32'h1000, NOP);
    tick();

    debug_start = 0;
    rst = 1; tick(); rst = 0;
    load(10, 32'h0AAA0AAA);
    load(11, 32'h0BBB0BBB);
    check("midload_count", 32'(load_count), 2);
    rst = 1; tick(); rst = 0;
    load(7, 32'h00700113);
    check("pre_start_core_en", 32'(core_en), 0);
    debug_start = 1; tick();
    check("rl_count", 32'(load_count), 1);
    check("rl_err", 32'(load_err), 0);
    check("rl_core_en", 32'(core_en), 1);
    fetch(32'h1C, 32'h00700113);
    fetch(32'h28, 32'h0AAA0AAA);

    fetch_en = 1; fetch_pc = 0; rst = 1; tick(); fetch_en = 0; rst = 0;
    check("rst_drop_valid", 32'(fetch_valid), 0);
    check("rst_drop_core_en", 32'(core_en), 0);
    tick(); tick();
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
